// File: rtl/spi_rd.sv
// Single-IO SPI byte read: LSB-first command byte out, then LSB-first data byte in. 42-cycle transfer.
// Requests are ignored while busy. RD_CMD_FORCE_READ_EN forces command bit 0 (read flag) to 1.
module spi_rd (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       rd_start_flag,
    input  logic [7:0] control_data,
    input  logic       rd_data_in,
    output logic       inout_en,
    output logic       sclk,
    output logic       wr_data,
    output logic       ce,
    output logic       now_rd,
    output logic [7:0] reg_data,
    output logic       rd_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t     state_q;
    logic [5:0] cnt_q, cnt_d;
    logic [7:0] cmd_q, cmd_d;
    logic [7:0] shift_q;
    logic [7:0] reg_data_q;
    logic       sclk_q, wr_data_q, ce_q, ce_dly_q, now_rd_q, rd_done_q;
    logic [2:0] bit_idx;
    logic       wr_slot, rd_slot, sclk_win;

`ifdef RD_CMD_FORCE_READ_EN
    assign cmd_d = {control_data[7:1], 1'b1};
`else
    assign cmd_d = control_data;
`endif

    assign cnt_d = (state_q == IDLE || (state_q == HOLD && cnt_q == 6'd41)) ? 6'd0 : cnt_q + 6'd1;

    // Command slots (cnt 6,8..20) and sample slots (cnt 23,25..37) share one index formula.
    assign bit_idx  = cnt_q[3:1] - 3'd3;
    assign wr_slot  = !cnt_q[0] && cnt_q >= 6'd6  && cnt_q <= 6'd20;
    assign rd_slot  =  cnt_q[0] && cnt_q >= 6'd23 && cnt_q <= 6'd37;
    assign sclk_win = cnt_q >= 6'd7 && cnt_q <= 6'd36;

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 6'd0;
            cmd_q      <= 8'h00;
            shift_q    <= 8'h00;
            reg_data_q <= 8'h00;
            sclk_q     <= 1'b0;
            wr_data_q  <= 1'b0;
            ce_q       <= 1'b0;
            ce_dly_q   <= 1'b0;
            now_rd_q   <= 1'b0;
            rd_done_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            case (state_q)
                IDLE: begin
                    now_rd_q <= rd_start_flag;
                    if (rd_start_flag) begin
                        state_q <= CMD;
                        cmd_q   <= cmd_d;
                    end
                end
                CMD:     if (cnt_q == 6'd22) state_q <= DATA;
                DATA:    if (cnt_q == 6'd38) state_q <= HOLD;
                HOLD:    if (cnt_q == 6'd41) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase

            ce_q      <= (state_q != IDLE);
            ce_dly_q  <= ce_q;
            rd_done_q <= ce_dly_q && !ce_q;
            sclk_q    <= sclk_win ? !sclk_q : 1'b0;

            if (cnt_q == 6'd22)
                wr_data_q <= 1'b0;
            else if (wr_slot)
                wr_data_q <= cmd_q[bit_idx];

            if (rd_slot)
                shift_q[bit_idx] <= rd_data_in;
            if (cnt_q == 6'd38)
                reg_data_q <= shift_q;
        end
    end

    assign inout_en = cnt_q >= 6'd4 && cnt_q <= 6'd22;
    assign sclk     = sclk_q;
    assign wr_data  = wr_data_q;
    assign ce       = ce_q;
    assign now_rd   = now_rd_q;
    assign reg_data = reg_data_q;
    assign rd_done  = rd_done_q;

endmodule

// File: tb/tb_spi_rd.sv
// Directed bench for spi_rd with a byte-serving device model on the IO pad.
`timescale 1ns/1ps
module tb_spi_rd;

    logic       sys_clk = 1'b0;
    logic       rst = 1'b0;
    logic       rd_start_flag = 1'b0;
    logic [7:0] control_data = 8'h00;
    logic       rd_data_in = 1'b0;
    logic       inout_en, sclk, wr_data, ce, now_rd, rd_done;
    logic [7:0] reg_data;

    int checks = 0;
    int failures = 0;

    logic [7:0] dev_byte = 8'h00;
    int         fc = 0;
    logic       ce_prev = 1'b0;
    logic       sclk_prev_m = 1'b0;

`ifdef RD_CMD_FORCE_READ_EN
    localparam logic FORCE = 1'b1;
`else
    localparam logic FORCE = 1'b0;
`endif

    typedef struct {
        logic [7:0] ctrl;
        logic [7:0] dev;
        logic [7:0] exp_cmd;
        logic [7:0] exp_reg;
    } vec_t;

    vec_t vecs[4];

    spi_rd dut (
        .sys_clk       (sys_clk),
        .rst           (rst),
        .rd_start_flag (rd_start_flag),
        .control_data  (control_data),
        .rd_data_in    (rd_data_in),
        .inout_en      (inout_en),
        .sclk          (sclk),
        .wr_data       (wr_data),
        .ce            (ce),
        .now_rd        (now_rd),
        .reg_data      (reg_data),
        .rd_done       (rd_done)
    );

    always #500 sys_clk = ~sys_clk;

    // Device: after the 8 command clocks, shifts one data bit out per sclk falling edge.
    always @(negedge sys_clk) begin
        if (ce && !ce_prev)
            fc = 0;
        if (!sclk && sclk_prev_m) begin
            fc = fc + 1;
            if (fc >= 8 && fc <= 15)
                rd_data_in = dev_byte[3'(fc - 8)];
        end
        ce_prev     = ce;
        sclk_prev_m = sclk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic start_xfer(input logic [7:0] ctrl, input logic [7:0] dev);
        dev_byte      = dev;
        control_data  = ctrl;
        rd_start_flag = 1'b1;
        @(negedge sys_clk);
        rd_start_flag = 1'b0;
    endtask

    // Called at the middle of the first cycle after the start edge (cnt_clk = 0).
    task automatic observe(input string tag, input logic [7:0] exp_cmd, input logic [7:0] exp_reg,
                           input int restart_at, input bit stop_on_done);
        int         ce_cnt;
        int         rises;
        int         done_cnt;
        int         done_t;
        int         first_ce;
        int         ioe_err;
        logic       sp;
        logic [7:0] cap;
        ce_cnt = 0; rises = 0; done_cnt = 0; done_t = -1; first_ce = -1; ioe_err = 0;
        sp = 1'b0; cap = 8'h00;
        for (int t = 0; t < 50; t++) begin
            if (t > 0) @(negedge sys_clk);
            if (t == restart_at + 1) rd_start_flag = 1'b0;
            if (t == 0) chk({tag, ".now_rd"}, 32'(now_rd), 32'd1);
            if (ce) begin
                ce_cnt++;
                if (first_ce < 0) first_ce = t;
            end
            if (inout_en !== (t >= 4 && t <= 22)) ioe_err++;
            if (sclk && !sp) begin
                if (rises < 8) cap[3'(rises)] = wr_data;
                rises++;
            end
            sp = sclk;
            if (rd_done) begin
                done_cnt++;
                done_t = t;
            end
            if (t == restart_at) rd_start_flag = 1'b1;
            if (rd_done && stop_on_done) break;
        end
        chk({tag, ".cmd_bits"}, 32'(cap), 32'(exp_cmd));
        chk({tag, ".reg_data"}, 32'(reg_data), 32'(exp_reg));
        chk({tag, ".done_cnt"}, done_cnt, 1);
        chk({tag, ".done_t"}, done_t, 44);
        chk({tag, ".ce_cycles"}, ce_cnt, 42);
        chk({tag, ".ce_first"}, first_ce, 1);
        chk({tag, ".sclk_rises"}, rises, 15);
        chk({tag, ".inout_en_err"}, ioe_err, 0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".ce"}, 32'(ce), 32'd0);
        chk({tag, ".sclk"}, 32'(sclk), 32'd0);
        chk({tag, ".wr_data"}, 32'(wr_data), 32'd0);
        chk({tag, ".now_rd"}, 32'(now_rd), 32'd0);
        chk({tag, ".rd_done"}, 32'(rd_done), 32'd0);
        chk({tag, ".inout_en"}, 32'(inout_en), 32'd0);
        chk({tag, ".reg_data"}, 32'(reg_data), 32'd0);
    endtask

    initial begin
        int n_done;
        int n_ce;

        vecs[0] = '{8'h81, 8'h59, 8'h81, 8'h59};
        vecs[1] = '{8'h80, 8'hA5, (FORCE ? 8'h81 : 8'h80), 8'hA5};
        vecs[2] = '{8'h3C, 8'h00, (FORCE ? 8'h3D : 8'h3C), 8'h00};
        vecs[3] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};

        rst = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk_idle_outputs("reset");
        rst = 1'b1;
        @(negedge sys_clk);

        for (int i = 0; i < 4; i++) begin
            start_xfer(vecs[i].ctrl, vecs[i].dev);
            observe($sformatf("vec%0d", i), vecs[i].exp_cmd, vecs[i].exp_reg, -1, 1'b0);
        end

        // Second request mid-transfer must be dropped.
        start_xfer(8'h81, 8'h3C);
        observe("restart", 8'h81, 8'h3C, 10, 1'b0);

        // Abort at cnt_clk = 30 after a completed 0x59 read.
        start_xfer(8'h81, 8'h59);
        observe("pre_rst", 8'h81, 8'h59, -1, 1'b0);
        start_xfer(8'h55, 8'h99);
        repeat (30) @(negedge sys_clk);
        chk("abort.sclk_before", 32'(sclk), 32'd1);
        rst = 1'b0;
        #1;
        chk_idle_outputs("abort");
        repeat (2) @(negedge sys_clk);
        rst = 1'b1;
        n_done = 0;
        n_ce = 0;
        repeat (50) begin
            @(negedge sys_clk);
            if (rd_done) n_done++;
            if (ce) n_ce++;
        end
        chk("abort.no_done", n_done, 0);
        chk("abort.no_ce", n_ce, 0);
        start_xfer(8'h03, 8'hA5);
        observe("post_rst", 8'h03, 8'hA5, -1, 1'b0);

        // Back-to-back: second request issued in the rd_done cycle.
        start_xfer(8'h0F, 8'h5A);
        observe("b2b_a", 8'h0F, 8'h5A, -1, 1'b1);
        start_xfer(8'hF0, 8'hC3);
        observe("b2b_b", (FORCE ? 8'hF1 : 8'hF0), 8'hC3, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
